// File: rtl/layer_priority_scheduler_if.sv
`default_nettype none
// ==========================================================================
// Module   : layer_priority_scheduler_if
// Brief    : Valid/ready configuration write port of the layer scheduler.
// Revision : 1.0 - initial release
// ==========================================================================
interface layer_priority_scheduler_if #(
  parameter int NUM_LAYERS = 4
);
  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic             cfgValid;
  logic [IDX_W-1:0] cfgLayer;
  logic [IDX_W-1:0] cfgRank;
  logic             cfgEnable;
  logic             cfgReady;

  modport master (output cfgValid, cfgLayer, cfgRank, cfgEnable, input cfgReady);
  modport slave  (input cfgValid, cfgLayer, cfgRank, cfgEnable, output cfgReady);
endinterface
`default_nettype wire

// File: rtl/layer_priority_scheduler.sv
`default_nettype none
// ==========================================================================
// Module   : layer_priority_scheduler
// Brief    : Priority arbiter for layered pixel colour with frame-aligned
//            reconfiguration and per-frame overlap reporting.
// Revision : 1.0 - initial release
// ==========================================================================
module layer_priority_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
  layer_priority_scheduler_if.slave   cfg,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [NUM_LAYERS-1:0]       collisionFlags
);
  localparam int               IDX_W       = $clog2(NUM_LAYERS);
  localparam logic [IDX_W:0]   c_LAYER_LIM = (IDX_W+1)'(NUM_LAYERS);
  localparam logic [1:0]       c_IDLE      = 2'd0;
  localparam logic [1:0]       c_PENDING   = 2'd1;
  localparam logic [1:0]       c_COMMIT    = 2'd2;

  logic [1:0]                  r_state;
  logic [IDX_W-1:0]            r_act_rank [NUM_LAYERS];
  logic [IDX_W-1:0]            r_shd_rank [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]       r_act_en;
  logic [NUM_LAYERS-1:0]       r_shd_en;
  logic [NUM_LAYERS-1:0]       r_s1_req;
  logic [NUM_LAYERS*RGB_W-1:0] r_s1_rgb;
  logic [RGB_W-1:0]            r_s1_bg;
  logic [NUM_LAYERS-1:0]       r_coll_acc;

  logic                        w_ready;
  logic                        w_cfg_fire;
  logic                        w_win_found;
  logic [IDX_W-1:0]            w_win_idx;
  logic [IDX_W-1:0]            w_win_rank;
  logic [NUM_LAYERS-1:0]       w_coll;
  logic [RGB_W-1:0]            w_pix;

  assign w_ready      = (r_state != c_COMMIT);
  assign cfg.cfgReady = w_ready;
  // Out-of-range layer indices complete the handshake but are otherwise inert.
  assign w_cfg_fire   = cfg.cfgValid && w_ready && ({1'b0, cfg.cfgLayer} < c_LAYER_LIM);

  // Strict less-than keeps the lowest index among equal ranks.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_win_rank  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (r_s1_req[i] && (!w_win_found || (r_act_rank[i] < w_win_rank))) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'(i);
        w_win_rank  = r_act_rank[i];
      end
    end
    w_coll = r_s1_req & ~({{(NUM_LAYERS-1){1'b0}}, 1'b1} << w_win_idx);
    w_pix  = w_win_found ? r_s1_rgb[w_win_idx*RGB_W +: RGB_W] : r_s1_bg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_act_en <= '1;
      r_shd_en <= '1;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_act_rank[i] <= IDX_W'(i);
        r_shd_rank[i] <= IDX_W'(i);
      end
    end else begin
      if (w_cfg_fire) begin
        r_shd_rank[cfg.cfgLayer] <= cfg.cfgRank;
        r_shd_en[cfg.cfgLayer]   <= cfg.cfgEnable;
      end
      case (r_state)
        c_IDLE:    if (w_cfg_fire)   r_state <= c_PENDING;
        c_PENDING: if (startOfFrame) r_state <= c_COMMIT;
        c_COMMIT: begin
          r_act_rank <= r_shd_rank;
          r_act_en   <= r_shd_en;
          r_state    <= c_IDLE;
        end
        default:   r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_req       <= '0;
      r_s1_rgb       <= '0;
      r_s1_bg        <= '0;
      RGBOut         <= '0;
      collisionFlags <= '0;
      r_coll_acc     <= '0;
    end else begin
      r_s1_req <= drawReq & r_act_en;
      r_s1_rgb <= layerRGB;
      r_s1_bg  <= backGroundRGB;
      RGBOut   <= w_pix;
      if (startOfFrame) begin
        collisionFlags <= r_coll_acc;
        r_coll_acc     <= '0;
      end else begin
        r_coll_acc <= r_coll_acc | w_coll;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_layer_priority_scheduler.sv
`default_nettype none
// ==========================================================================
// Module   : tb_layer_priority_scheduler
// Brief    : Scoreboard bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ==========================================================================
module tb_layer_priority_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [3:0]  drawReq;
  logic [31:0] layerRGB;
  logic [7:0]  backGroundRGB;
  logic [7:0]  RGBOut;
  logic [3:0]  collisionFlags;

  logic        sof3;
  logic [2:0]  req3;
  logic [23:0] rgb3;
  logic [7:0]  bg3;
  logic [7:0]  rgbout3;
  logic [2:0]  col3;

  layer_priority_scheduler_if #(.NUM_LAYERS(4)) cif ();
  layer_priority_scheduler_if #(.NUM_LAYERS(3)) cif3 ();

  layer_priority_scheduler #(.NUM_LAYERS(4), .RGB_W(8)) u_dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .drawReq(drawReq),
    .layerRGB(layerRGB), .backGroundRGB(backGroundRGB), .cfg(cif),
    .RGBOut(RGBOut), .collisionFlags(collisionFlags)
  );

  // Three layers leave cfgLayer=3 unrepresented, exercising the range guard.
  layer_priority_scheduler #(.NUM_LAYERS(3), .RGB_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .startOfFrame(sof3), .drawReq(req3),
    .layerRGB(rgb3), .backGroundRGB(bg3), .cfg(cif3),
    .RGBOut(rgbout3), .collisionFlags(col3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [7:0] val; } exp_t;
  exp_t q_rgb[$];
  exp_t q_col[$];
  exp_t q_rdy[$];
  exp_t me;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_rank[4];
  int         s_rank[4];
  bit         m_en[4];
  bit         s_en[4];
  bit         m_pending;
  int         commit_cycle;
  int         commit_at;
  logic [3:0] acc;
  bit         p_valid;
  logic [3:0] p_req;
  logic [7:0] p_rgb[4];
  logic [7:0] p_bg;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rank[i] = i; s_rank[i] = i; m_en[i] = 1'b1; s_en[i] = 1'b1;
    end
    m_pending = 1'b0; commit_cycle = -1; commit_at = -1;
    acc = '0; p_valid = 1'b0;
    q_rgb.delete(); q_col.delete(); q_rdy.delete();
  endtask

  // One pixel-clock cycle of stimulus; the model works from layer ranks and frame events.
  task automatic cycle(input bit isof, input logic [3:0] req, input logic [31:0] rgbs,
                       input logic [7:0] bgc, input bit cv, input int cl, input int cr,
                       input bit ce);
    bit         rdy;
    bit         was_pending;
    int         best;
    logic [3:0] contrib;
    @(posedge clk); #1;
    if (commit_at >= 0 && cyc >= commit_at) begin
      m_rank = s_rank; m_en = s_en; commit_at = -1;
    end
    startOfFrame = isof; drawReq = req; layerRGB = rgbs; backGroundRGB = bgc;
    cif.cfgValid = cv; cif.cfgLayer = 2'(cl); cif.cfgRank = 2'(cr); cif.cfgEnable = ce;
    rdy = (cyc != commit_cycle);
    q_rdy.push_back('{cyc, {7'b0, rdy}});
    contrib = '0;
    if (p_valid) begin
      best = -1;
      for (int r = 0; r < 4 && best < 0; r++)
        for (int i = 0; i < 4 && best < 0; i++)
          if (p_req[i] && m_rank[i] == r) best = i;
      q_rgb.push_back('{cyc + 1, (best < 0) ? p_bg : p_rgb[best]});
      for (int i = 0; i < 4; i++) if (p_req[i] && i != best) contrib[i] = 1'b1;
    end
    if (isof) begin
      q_col.push_back('{cyc + 1, {4'b0, acc}});
      acc = '0;
    end else begin
      acc = acc | contrib;
    end
    was_pending = m_pending;
    if (cv && rdy) begin
      s_rank[cl] = cr; s_en[cl] = ce; m_pending = 1'b1;
    end
    if (isof && was_pending) begin
      commit_cycle = cyc + 1; commit_at = cyc + 2; m_pending = 1'b0;
    end
    p_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_req[i] = req[i] && m_en[i];
      p_rgb[i] = rgbs[i*8 +: 8];
    end
    p_bg = bgc;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q_rgb.size() + q_col.size() + q_rdy.size()) != 0 && guard < 8) begin
      @(negedge clk); #1; guard++;
    end
    if ((q_rgb.size() + q_col.size() + q_rdy.size()) != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d entries outstanding, expected 0",
               q_rgb.size() + q_col.size() + q_rdy.size());
      q_rgb.delete(); q_col.delete(); q_rdy.delete();
    end
  endtask

  task automatic quiesce();
    repeat (3) cycle(1'b0, 4'b0, 32'h0, 8'h0, 1'b0, 0, 0, 1'b1);
    p_valid = 1'b0;
    drain();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
        me = q_rgb.pop_front();
        if (me.due < cyc) begin n_chk++; n_fail++; $display("FAIL rgb_late: got none, expected %h", me.val); end
        else chk("rgb", RGBOut, me.val);
      end
      while (q_col.size() > 0 && q_col[0].due <= cyc) begin
        me = q_col.pop_front();
        if (me.due < cyc) begin n_chk++; n_fail++; $display("FAIL col_late: got none, expected %h", me.val); end
        else chk("collision", {4'b0, collisionFlags}, me.val);
      end
      while (q_rdy.size() > 0 && q_rdy[0].due <= cyc) begin
        me = q_rdy.pop_front();
        if (me.due < cyc) begin n_chk++; n_fail++; $display("FAIL rdy_late: got none, expected %h", me.val); end
        else chk("cfgReady", {7'b0, cif.cfgReady}, me.val);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] c_RGB_A = 32'h00E01C00;
  localparam logic [31:0] c_RGB_B = 32'h55E01CAA;

  initial begin
    reset = 1'b0; startOfFrame = 1'b0; drawReq = '0; layerRGB = '0; backGroundRGB = '0;
    cif.cfgValid = 1'b0; cif.cfgLayer = '0; cif.cfgRank = '0; cif.cfgEnable = 1'b0;
    sof3 = 1'b0; req3 = '0; rgb3 = '0; bg3 = '0;
    cif3.cfgValid = 1'b0; cif3.cfgLayer = '0; cif3.cfgRank = '0; cif3.cfgEnable = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset_rgb", RGBOut, 8'h00);
    chk("reset_col", {4'b0, collisionFlags}, 8'h00);
    chk("reset_rdy", {7'b0, cif.cfgReady}, 8'h01);
    @(negedge clk); #1 reset = 1'b0;
    model_reset();

    // Default priorities: layer1 over layer2, layer2 reported as overlapped.
    repeat (3) cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t1_rgb", RGBOut, 8'h1C);
    cycle(1'b1, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t1_col", {4'b0, collisionFlags}, 8'h04);

    repeat (3) cycle(1'b0, 4'b0000, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t2_bg", RGBOut, 8'h03);

    // Deferred commit of layer2 -> rank 0.
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b1, 2, 0, 1'b1);
    repeat (3) cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t3_before", RGBOut, 8'h1C);
    cycle(1'b1, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t3_rdy_low", {7'b0, cif.cfgReady}, 8'h00);
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t3_rdy_high", {7'b0, cif.cfgReady}, 8'h01);
    repeat (2) cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t3_after", RGBOut, 8'hE0);

    // Hide layer1.
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b1, 1, 1, 1'b0);
    cycle(1'b1, 4'b0010, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    repeat (4) cycle(1'b0, 4'b0010, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t4_hidden", RGBOut, 8'h03);
    cycle(1'b1, 4'b0010, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    cycle(1'b0, 4'b0010, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t4_col", {4'b0, collisionFlags}, 8'h00);

    // Write coincident with startOfFrame while pending, then a rank tie.
    cycle(1'b0, 4'b1001, c_RGB_B, 8'h03, 1'b1, 3, 0, 1'b1);
    cycle(1'b1, 4'b1001, c_RGB_B, 8'h03, 1'b1, 0, 3, 1'b1);
    repeat (4) cycle(1'b0, 4'b1001, c_RGB_B, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t5_coincident", RGBOut, 8'h55);
    repeat (3) cycle(1'b0, 4'b1100, c_RGB_B, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t5_tie", RGBOut, 8'hE0);
    quiesce();

    // Out-of-range layer on the three-layer instance.
    @(posedge clk); #1;
    cif3.cfgValid = 1'b1; cif3.cfgLayer = 2'd3; cif3.cfgRank = 2'd0; cif3.cfgEnable = 1'b0;
    req3 = 3'b111; rgb3 = 24'h332211; bg3 = 8'h07;
    @(negedge clk); chk("t5_oor_handshake", {7'b0, cif3.cfgReady}, 8'h01);
    @(posedge clk); #1; cif3.cfgValid = 1'b0; sof3 = 1'b1;
    @(posedge clk); #1; sof3 = 1'b0;
    @(negedge clk);
    chk("t5_oor_nostate", {7'b0, cif3.cfgReady}, 8'h01);
    chk("t5_oor_rgb", rgbout3, 8'h11);

    // Reset while a write is pending.
    cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b1, 1, 3, 1'b0);
    quiesce();
    @(negedge clk); #1 reset = 1'b1; #1;
    chk("t6_rgb", RGBOut, 8'h00);
    chk("t6_col", {4'b0, collisionFlags}, 8'h00);
    chk("t6_rdy", {7'b0, cif.cfgReady}, 8'h01);
    @(negedge clk); #1 reset = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0, 4'b0110, c_RGB_A, 8'h03, 1'b0, 0, 0, 1'b1);
    @(negedge clk); chk("t6_defaults", RGBOut, 8'h1C);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 15) == 0), 4'($urandom), $urandom, 8'($urandom),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
